// File: rtl/dvp_pattern_source.sv
// OV7670-style DVP test-pattern transmitter: pclk = clk_i/2, vsync/href/data change on pclk falling edges.
// Optional macro DVP_TX_LINE_ID_EN replaces pixel 0 of every active row with the 12-bit row number.
module dvp_pattern_source #(
   parameter int unsigned ACTIVE_COLUMNS = 640,
   parameter int unsigned ACTIVE_ROWS    = 480,
   parameter int unsigned HBLANK_PCLKS   = 144,
   parameter int unsigned VSYNC_LINES    = 3,
   parameter int unsigned VBACK_LINES    = 17,
   parameter int unsigned VFRONT_LINES   = 10
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic [1:0]  pattern_sel_i,
   input  logic [11:0] solid_color_i,
   output logic        pixel_clk_cmos_o,
   output logic        vsync_cmos_o,
   output logic        href_cmos_o,
   output logic [7:0]  pixel_data_cmos_o,
   output logic        busy_o,
   output logic        frame_done_o
);

   localparam int unsigned LINE_PCLKS   = 2 * ACTIVE_COLUMNS + HBLANK_PCLKS;
   localparam int unsigned HREF_TICKS   = 2 * ACTIVE_COLUMNS;
   localparam int unsigned VSYNC_TICKS  = VSYNC_LINES * LINE_PCLKS;
   localparam int unsigned VBACK_TICKS  = VBACK_LINES * LINE_PCLKS;
   localparam int unsigned VFRONT_TICKS = VFRONT_LINES * LINE_PCLKS;
   localparam int unsigned MAX_AB       = (VSYNC_TICKS > VBACK_TICKS) ? VSYNC_TICKS : VBACK_TICKS;
   localparam int unsigned MAX_ABC      = (MAX_AB > VFRONT_TICKS) ? MAX_AB : VFRONT_TICKS;
   localparam int unsigned MAX_TICKS    = (MAX_ABC > LINE_PCLKS) ? MAX_ABC : LINE_PCLKS;
   localparam int unsigned CNT_W        = $clog2(MAX_TICKS + 1);
   localparam int unsigned ROW_W        = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBACK,
      ST_ACTIVE,
      ST_VFRONT
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic               pclk_q;
   logic               vsync_q, vsync_d;
   logic               href_q, href_d;
   logic [7:0]         data_q, data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [1:0]         pat_q, pat_d;
   logic [11:0]        solid_q, solid_d;
   logic               tick;
   logic [11:0]        pix_x, pix_y;
   logic [2:0]         bar_idx;
   logic [11:0]        pix_color;

   // Falling edge of the DVP clock: the only point where the frame advances.
   assign tick = pclk_q;

   function automatic logic [11:0] bar_color(input logic [2:0] idx);
      logic [11:0] c;
      case (idx)
         3'd0:    c = 12'hFFF;
         3'd1:    c = 12'hFF0;
         3'd2:    c = 12'h0FF;
         3'd3:    c = 12'h0F0;
         3'd4:    c = 12'hF0F;
         3'd5:    c = 12'hF00;
         3'd6:    c = 12'h00F;
         default: c = 12'h000;
      endcase
      return c;
   endfunction

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and position counters; they describe the pclk period that starts at this tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (enable_i) begin
                  state_d = ST_VSYNC;
                  cnt_d   = '0;
               end
            end
            ST_VSYNC: begin
               if (cnt_q == CNT_W'(VSYNC_TICKS - 1)) begin
                  state_d = ST_VBACK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_VBACK: begin
               if (cnt_q == CNT_W'(VBACK_TICKS - 1)) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = '0;
                  row_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_ACTIVE: begin
               if (cnt_q == CNT_W'(LINE_PCLKS - 1)) begin
                  cnt_d = '0;
                  if (row_q == ROW_W'(ACTIVE_ROWS - 1)) begin
                     state_d = ST_VFRONT;
                     row_d   = '0;
                  end else begin
                     row_d = row_q + ROW_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_VFRONT: begin
               if (cnt_q == CNT_W'(VFRONT_TICKS - 1)) begin
                  state_d = enable_i ? ST_VSYNC : ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               row_d   = '0;
            end
         endcase
      end
   end

   // Pixel colour for the upcoming period, computed from the next position so data lines up with href.
   always_comb begin
      pix_x   = 12'(cnt_d >> 1);
      pix_y   = 12'(row_d);
      bar_idx = 3'((32'(pix_x) * 32'd8) / 32'(ACTIVE_COLUMNS));
      case (pat_q)
         2'd0:    pix_color = bar_color(bar_idx);
         2'd1:    pix_color = 12'(32'(pix_y) * 32'(ACTIVE_COLUMNS) + 32'(pix_x));
         2'd2:    pix_color = solid_q;
         default: pix_color = (pix_x[3] ^ pix_y[3]) ? 12'hFFF : 12'h000;
      endcase
`ifdef DVP_TX_LINE_ID_EN
      if (cnt_d < CNT_W'(2)) begin
         pix_color = pix_y;
      end
`else
`endif
   end

   // Output and latch next-values; frame_done self-clears on the following clk_i edge.
   always_comb begin
      vsync_d = vsync_q;
      href_d  = href_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pat_d   = pat_q;
      solid_d = solid_q;
      if (tick) begin
         vsync_d = (state_d == ST_VSYNC);
         href_d  = (state_d == ST_ACTIVE) && (cnt_d < CNT_W'(HREF_TICKS));
         data_d  = href_d ? (cnt_d[0] ? pix_color[7:0] : {4'h0, pix_color[11:8]}) : 8'h00;
         busy_d  = (state_d != ST_IDLE);
         done_d  = (state_q == ST_VFRONT) && (state_d != ST_VFRONT);
         if ((state_d == ST_VSYNC) && (state_q != ST_VSYNC)) begin
            pat_d   = pattern_sel_i;
            solid_d = solid_color_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q   <= '0;
         row_q   <= '0;
         pclk_q  <= 1'b0;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         data_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pat_q   <= 2'd0;
         solid_q <= 12'h000;
      end else begin
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         pclk_q  <= ~pclk_q;
         vsync_q <= vsync_d;
         href_q  <= href_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pat_q   <= pat_d;
         solid_q <= solid_d;
      end
   end

   assign pixel_clk_cmos_o  = pclk_q;
   assign vsync_cmos_o      = vsync_q;
   assign href_cmos_o       = href_q;
   assign pixel_data_cmos_o = data_q;
   assign busy_o            = busy_q;
   assign frame_done_o      = done_q;

endmodule

// File: tb/tb_dvp_pattern_source.sv
// Self-checking bench for dvp_pattern_source: scoreboarded byte streams plus frame timing checks.
// Honors DVP_TX_LINE_ID_EN in its expected-pixel model.
`timescale 1ns/1ps
module tb_dvp_pattern_source;

   localparam int COLS   = 16;
   localparam int ROWS   = 4;
   localparam int HBL    = 4;
   localparam int VS     = 1;
   localparam int VB     = 1;
   localparam int VF     = 1;
   localparam int LINE   = 2 * COLS + HBL;
   localparam int FRAME  = (VS + VB + ROWS + VF) * LINE;
   localparam int BUDGET = 2 * FRAME + 100;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        enable_i = 1'b0;
   logic [1:0]  pattern_sel_i = 2'd0;
   logic [11:0] solid_color_i = 12'h000;
   logic        pixel_clk_cmos_o;
   logic        vsync_cmos_o;
   logic        href_cmos_o;
   logic [7:0]  pixel_data_cmos_o;
   logic        busy_o;
   logic        frame_done_o;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] cap_q[$];
   int         href_len_q[$];
   int cap_ticks, cap_vs_ticks, cap_first_href, cap_stray, cap_done_pulses, cap_done_at, cap_timeout;

   dvp_pattern_source #(
      .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .HBLANK_PCLKS(HBL),
      .VSYNC_LINES(VS), .VBACK_LINES(VB), .VFRONT_LINES(VF)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
      .pattern_sel_i(pattern_sel_i), .solid_color_i(solid_color_i),
      .pixel_clk_cmos_o(pixel_clk_cmos_o), .vsync_cmos_o(vsync_cmos_o),
      .href_cmos_o(href_cmos_o), .pixel_data_cmos_o(pixel_data_cmos_o),
      .busy_o(busy_o), .frame_done_o(frame_done_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [11:0] exp_color(input logic [1:0] pat, input logic [11:0] solid,
                                             input int x, input int y);
      logic [11:0] c;
      int b;
      b = (x * 8) / COLS;
      case (pat)
         2'd0: begin
            case (b)
               0: c = 12'hFFF;
               1: c = 12'hFF0;
               2: c = 12'h0FF;
               3: c = 12'h0F0;
               4: c = 12'hF0F;
               5: c = 12'hF00;
               6: c = 12'h00F;
               default: c = 12'h000;
            endcase
         end
         2'd1: c = 12'((y * COLS + x) % 4096);
         2'd2: c = solid;
         default: c = ((((x >> 3) & 1) ^ ((y >> 3) & 1)) != 0) ? 12'hFFF : 12'h000;
      endcase
`ifdef DVP_TX_LINE_ID_EN
      if (x == 0) c = 12'(y);
`else
`endif
      return c;
   endfunction

   task automatic push_frame(input logic [1:0] pat, input logic [11:0] solid);
      logic [11:0] c;
      for (int y = 0; y < ROWS; y++) begin
         for (int x = 0; x < COLS; x++) begin
            c = exp_color(pat, solid, x, y);
            exp_q.push_back({4'h0, c[11:8]});
            exp_q.push_back(c[7:0]);
         end
      end
   endtask

   // Collects one frame as seen at pclk rising edges, from the first vsync period to frame_done.
   task automatic capture_frame(input int budget);
      bit started, done_seen;
      int post, run;
      cap_q.delete();
      href_len_q.delete();
      cap_ticks = 0; cap_vs_ticks = 0; cap_first_href = -1; cap_stray = 0;
      cap_done_pulses = 0; cap_done_at = -1; cap_timeout = 0;
      started = 0; done_seen = 0; post = 0; run = 0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk_i);
         if (!started && pixel_clk_cmos_o === 1'b1 && vsync_cmos_o === 1'b1) started = 1;
         if (started) begin
            if (frame_done_o === 1'b1) begin
               cap_done_pulses++;
               if (!done_seen) cap_done_at = cap_ticks;
               done_seen = 1;
            end
            if (pixel_clk_cmos_o === 1'b1 && !done_seen) begin
               if (vsync_cmos_o === 1'b1) cap_vs_ticks++;
               if (href_cmos_o === 1'b1) begin
                  cap_q.push_back(pixel_data_cmos_o);
                  run++;
                  if (cap_first_href < 0) cap_first_href = cap_ticks;
               end else begin
                  if (run > 0) href_len_q.push_back(run);
                  run = 0;
                  if (pixel_data_cmos_o !== 8'h00) cap_stray++;
               end
               cap_ticks++;
            end
            if (done_seen) begin
               post++;
               if (post >= 3) break;
            end
         end
      end
      if (!done_seen) cap_timeout = 1;
   endtask

   task automatic test_reset();
      logic p0;
      reset_i = 1'b1; enable_i = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({pixel_clk_cmos_o, vsync_cmos_o, href_cmos_o, pixel_data_cmos_o, busy_o, frame_done_o} !== 13'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0000",
                  {pixel_clk_cmos_o, vsync_cmos_o, href_cmos_o, pixel_data_cmos_o, busy_o, frame_done_o});
      end
      reset_i = 1'b0;
      @(negedge clk_i); p0 = pixel_clk_cmos_o;
      @(negedge clk_i);
      checks++;
      if (p0 !== 1'b1) begin failures++; $display("FAIL pclk_first: got %b expected 1", p0); end
      checks++;
      if (pixel_clk_cmos_o !== 1'b0) begin failures++; $display("FAIL pclk_toggle: got %b expected 0", pixel_clk_cmos_o); end
      repeat (20) @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || vsync_cmos_o !== 1'b0) begin
         failures++; $display("FAIL idle_after_reset: got busy=%b vsync=%b expected 0/0", busy_o, vsync_cmos_o);
      end
   endtask

   task automatic test_index_frame();
      logic [7:0] e, g;
      int k;
      exp_q.delete();
      push_frame(2'd1, 12'h000);
      pattern_sel_i = 2'd1; enable_i = 1'b1;
      fork
         capture_frame(BUDGET);
         begin repeat (20) @(negedge clk_i); enable_i = 1'b0; end
      join
      checks++; if (cap_timeout !== 0) begin failures++; $display("FAIL index_timeout: got %0d expected 0", cap_timeout); end
      checks++; if (cap_vs_ticks !== VS * LINE) begin failures++; $display("FAIL vsync_len: got %0d expected %0d", cap_vs_ticks, VS * LINE); end
      checks++; if (cap_first_href !== (VS + VB) * LINE) begin failures++; $display("FAIL first_href: got %0d expected %0d", cap_first_href, (VS + VB) * LINE); end
      checks++; if (href_len_q.size() !== ROWS) begin failures++; $display("FAIL href_pulses: got %0d expected %0d", href_len_q.size(), ROWS); end
      foreach (href_len_q[i]) begin
         checks++;
         if (href_len_q[i] !== 2 * COLS) begin failures++; $display("FAIL href_len[%0d]: got %0d expected %0d", i, href_len_q[i], 2 * COLS); end
      end
      checks++; if (cap_stray !== 0) begin failures++; $display("FAIL data_outside_href: got %0d expected 0", cap_stray); end
      checks++; if (cap_done_pulses !== 1) begin failures++; $display("FAIL done_width: got %0d expected 1", cap_done_pulses); end
      checks++; if (cap_done_at !== FRAME) begin failures++; $display("FAIL done_tick: got %0d expected %0d", cap_done_at, FRAME); end
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin failures++; $display("FAIL index_byte[%0d]: got %h expected %h", k, g, e); end
         k++;
      end
      checks++; if (cap_q.size() !== 0) begin failures++; $display("FAIL index_extra: got %0d expected 0", cap_q.size()); end
      checks++; if (busy_o !== 1'b0 || vsync_cmos_o !== 1'b0) begin failures++; $display("FAIL index_idle: got busy=%b vsync=%b expected 0/0", busy_o, vsync_cmos_o); end
   endtask

   task automatic test_bars();
      logic [7:0] e, g;
      int k;
      exp_q.delete();
      push_frame(2'd0, 12'h000);
      pattern_sel_i = 2'd0; enable_i = 1'b1;
      fork
         capture_frame(BUDGET);
         begin repeat (20) @(negedge clk_i); enable_i = 1'b0; pattern_sel_i = 2'd3; end
      join
      checks++; if (cap_done_at !== FRAME) begin failures++; $display("FAIL bars_done_tick: got %0d expected %0d", cap_done_at, FRAME); end
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin failures++; $display("FAIL bars_byte[%0d]: got %h expected %h", k, g, e); end
         k++;
      end
      checks++; if (cap_q.size() !== 0) begin failures++; $display("FAIL bars_extra: got %0d expected 0", cap_q.size()); end
   endtask

   task automatic test_solid_back_to_back();
      logic [7:0] e, g;
      int k;
      exp_q.delete();
      push_frame(2'd2, 12'hA5C);
      pattern_sel_i = 2'd2; solid_color_i = 12'hA5C; enable_i = 1'b1;
      fork
         capture_frame(BUDGET);
         begin repeat (250) @(negedge clk_i); solid_color_i = 12'h123; end
      join
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin failures++; $display("FAIL solid1_byte[%0d]: got %h expected %h", k, g, e); end
         k++;
      end
      checks++;
      if (vsync_cmos_o !== 1'b1 || busy_o !== 1'b1) begin
         failures++; $display("FAIL back_to_back: got vsync=%b busy=%b expected 1/1", vsync_cmos_o, busy_o);
      end
      push_frame(2'd2, 12'h123);
      enable_i = 1'b0;
      capture_frame(BUDGET);
      checks++; if (cap_done_pulses !== 1) begin failures++; $display("FAIL solid2_done: got %0d expected 1", cap_done_pulses); end
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin failures++; $display("FAIL solid2_byte[%0d]: got %h expected %h", k, g, e); end
         k++;
      end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL solid2_idle: got busy=%b expected 0", busy_o); end
   endtask

   task automatic test_enable_drop();
      logic [7:0] e, g;
      logic [11:0] c;
      int k, vs_hi;
      exp_q.delete();
      push_frame(2'd3, 12'h000);
      pattern_sel_i = 2'd3; enable_i = 1'b1;
      fork
         capture_frame(BUDGET);
         begin
            for (int i = 0; i < 50 && vsync_cmos_o !== 1'b1; i++) @(negedge clk_i);
            repeat (300) @(negedge clk_i);
            enable_i = 1'b0;
         end
      join
      checks++; if (href_len_q.size() !== ROWS) begin failures++; $display("FAIL drop_rows: got %0d expected %0d", href_len_q.size(), ROWS); end
      checks++; if (cap_done_pulses !== 1) begin failures++; $display("FAIL drop_done: got %0d expected 1", cap_done_pulses); end
      c = exp_color(2'd3, 12'h000, 0, 3);
      checks++;
      if (cap_q.size() < 98 || cap_q[96] !== {4'h0, c[11:8]} || cap_q[97] !== c[7:0]) begin
         failures++; $display("FAIL row3_px0: got %h%h expected %h%h",
                              (cap_q.size() > 96) ? cap_q[96] : 8'hxx, (cap_q.size() > 97) ? cap_q[97] : 8'hxx,
                              {4'h0, c[11:8]}, c[7:0]);
      end
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin failures++; $display("FAIL checker_byte[%0d]: got %h expected %h", k, g, e); end
         k++;
      end
      vs_hi = 0;
      repeat (120) begin
         @(negedge clk_i);
         if (vsync_cmos_o !== 1'b0) vs_hi++;
      end
      checks++; if (vs_hi !== 0) begin failures++; $display("FAIL drop_no_vsync: got %0d expected 0", vs_hi); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL drop_busy: got %b expected 0", busy_o); end
   endtask

   task automatic test_reset_mid_active();
      logic p0;
      int n, vs_hi;
      pattern_sel_i = 2'd0; enable_i = 1'b1;
      n = 0;
      while (href_cmos_o !== 1'b1 && n < BUDGET) begin @(negedge clk_i); n++; end
      checks++; if (n >= BUDGET) begin failures++; $display("FAIL href_wait: got timeout expected href"); end
      enable_i = 1'b0;
      repeat (5) @(negedge clk_i);
      #2 reset_i = 1'b1;
      #1;
      checks++;
      if ({pixel_clk_cmos_o, vsync_cmos_o, href_cmos_o, pixel_data_cmos_o, busy_o, frame_done_o} !== 13'h0) begin
         failures++;
         $display("FAIL async_reset: got %h expected 0000",
                  {pixel_clk_cmos_o, vsync_cmos_o, href_cmos_o, pixel_data_cmos_o, busy_o, frame_done_o});
      end
      @(negedge clk_i); reset_i = 1'b0;
      @(negedge clk_i); p0 = pixel_clk_cmos_o;
      @(negedge clk_i);
      checks++;
      if (p0 !== 1'b1 || pixel_clk_cmos_o !== 1'b0) begin
         failures++; $display("FAIL pclk_after_reset: got %b%b expected 10", p0, pixel_clk_cmos_o);
      end
      vs_hi = 0;
      repeat (100) begin
         @(negedge clk_i);
         if (vsync_cmos_o !== 1'b0 || busy_o !== 1'b0) vs_hi++;
      end
      checks++; if (vs_hi !== 0) begin failures++; $display("FAIL idle_after_mid_reset: got %0d expected 0", vs_hi); end
   endtask

   initial begin
      test_reset();
      test_index_frame();
      test_bars();
      test_solid_back_to_back();
      test_enable_drop();
      test_reset_mid_active();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dvp_pattern_source.md
Name: dvp_pattern_source

Overview:
- Synthesizable OV7670-style DVP transmitter: generates pixel_clk/vsync/href/8-bit data exactly as the sensor drives the camera capture path.
- Streams RGB444 test frames (2 bytes/pixel) so the capture/VRAM path can be verified and demoed without a physical camera.
- Sits beside the sensor pins; a board-level mux selects sensor or this block.

Parameters:
- ACTIVE_COLUMNS, 640, pixels per active line
- ACTIVE_ROWS, 480, active lines per frame
- HBLANK_PCLKS, 144, href-low pclk ticks after each active line
- VSYNC_LINES, 3, line periods with vsync high
- VBACK_LINES, 17, blank line periods after vsync
- VFRONT_LINES, 10, blank line periods after last active line

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous active-high reset
- enable_i  in  1  run request
- pattern_sel_i  in  2  0 bars, 1 index, 2 solid, 3 checker
- solid_color_i  in  12  {R,G,B} for pattern 2
- pixel_clk_cmos_o  out  1  DVP pixel clock (clk_i/2)
- vsync_cmos_o  out  1  frame sync, active high
- href_cmos_o  out  1  line valid
- pixel_data_cmos_o  out  8  DVP data byte
- busy_o  out  1  frame in progress
- frame_done_o  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, active-high): all outputs 0, FSM IDLE, counters 0.
- pixel_clk_cmos_o toggles every clk_i cycle out of reset, including in IDLE. A "tick" is a clk_i edge where pixel_clk_cmos_o is 1 (its falling edge).
- vsync/href/data change only on ticks, so they are stable at the pclk rising edge.
- LINE_PCLKS = 2*ACTIVE_COLUMNS + HBLANK_PCLKS.
- FSM, advanced on ticks only:
  - IDLE: outputs low. If enable_i=1 at a tick: latch pattern_sel_i and solid_color_i, busy_o=1, go to VSYNC. vsync rises on that same tick.
  - VSYNC: vsync=1, href=0 for VSYNC_LINES*LINE_PCLKS ticks, then VBACK.
  - VBACK: both low for VBACK_LINES*LINE_PCLKS ticks, then ACTIVE.
  - ACTIVE: per row, href=1 for 2*ACTIVE_COLUMNS ticks, then href=0 for HBLANK_PCLKS ticks. After ACTIVE_ROWS rows, go to VFRONT.
  - VFRONT: both low for VFRONT_LINES*LINE_PCLKS ticks. At the last tick, frame_done_o pulses for 1 clk_i cycle. Then go to VSYNC (re-latch pattern) if enable_i=1, else IDLE with busy_o=0.
- enable_i deasserted mid-frame: the frame completes normally; no truncated frames.
- Byte order per pixel: byte0 = {4'h0, R}, byte1 = {G, B}.
- Data is 0 whenever href=0.
- x = pixel column 0..ACTIVE_COLUMNS-1, y = active row. Both wrap to 0 at line/frame end.
- Patterns (selection latched per frame):
  - 0, bars: index = x*8/ACTIVE_COLUMNS (integer). Colors FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - 1, index: value = (y*ACTIVE_COLUMNS + x) mod 4096.
  - 2, solid: latched solid_color_i.
  - 3, checker: FFF if x[3]^y[3], else 000.
- Pattern pipeline is internal; pixel values must align exactly with href (no leading or trailing bytes).

Optional Feature:
- Macro DVP_TX_LINE_ID_EN.
- Defined: pixel x=0 of every active row is replaced by the 12-bit row number: byte0 = {4'h0, y[11:8]}, byte1 = y[7:0]. Other pixels are unchanged.
- Undefined: no substitution, and the logic is absent.

Test Plan:
- Bench parameters: COLS=16, ROWS=4, HBLANK=4, VSYNC=1, VBACK=1, VFRONT=1; LINE_PCLKS=36, frame=252 ticks=504 clk_i.
- Reset mid-ACTIVE -> all outputs 0 immediately (async); after release, pixel_clk_cmos_o toggles and FSM is IDLE (busy_o=0).
- enable_i=1, pattern 1 -> vsync high 36 ticks; 4 href pulses of 32 ticks each; byte stream 00,00,00,01,...,00,3F for 64 pixels; frame_done_o pulses once at tick 252.
- Pattern 0 -> pixels 0-1 = 0F,FF; pixels 2-3 = 0F,F0; ...; pixels 14-15 = 00,00.
- Pattern 2 with solid_color_i=0xA5C, changed to 0x123 mid-frame -> every pixel 0A,5C for the whole frame; 0x123 appears from the next frame.
- enable_i dropped during row 2 -> rows 2-3 and VFRONT complete, frame_done_o pulses, then IDLE with no new vsync. With DVP_TX_LINE_ID_EN, pixel 0 of row 3 = 00,03.
